// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings and FSM states for the byte-serial RAM arbiter
package mem_arbiter_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF = 2'b01;
  localparam logic [1:0] OWN_MEM = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    return len == LEN_B ? 3'd1 : len == LEN_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF, MEM and RAM-side signals of the arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_data_o;
  logic mem_req_i, mem_we_i, mem_done_o;
  logic [1:0] mem_len_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_data_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic ram_wr_o;
  logic [7:0] ram_dout_o, ram_din_i;
  logic [1:0] owner_o;
  logic busy_o;
  modport slave(
    input if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    output if_done_o, if_data_o, mem_done_o, mem_data_o, ram_addr_o, ram_wr_o, ram_dout_o, owner_o, busy_o
  );
  modport master(
    output if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i, ram_din_i,
    input if_done_o, if_data_o, mem_done_o, mem_data_o, ram_addr_o, ram_wr_o, ram_dout_o, owner_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between IF and MEM, sequencing bytes little-endian
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_t r_state, w_state_n;
  logic [1:0] r_owner;
  logic r_we, r_if_done, r_mem_done, r_ram_wr;
  logic [2:0] r_n, r_k;
  logic [31:0] r_addr, r_wdata, r_data, r_if_data, r_mem_data;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0] r_ram_dout;
  logic w_mem_go, w_if_go, w_flush, w_last;
  logic [31:0] w_byte_addr, w_rdata;
  always_comb begin
    w_mem_go = r_state == S_IDLE && bus.mem_req_i;
    w_if_go = r_state == S_IDLE && !bus.mem_req_i && bus.if_req_i && !bus.if_flush_i;
    w_flush = r_state == S_XFER && r_owner == OWN_IF && bus.if_flush_i;
    w_last = r_k == r_n;
    w_byte_addr = r_addr + {29'd0, r_k};
    // k counts edges in XFER; the byte read back at edge k belongs to lane k-1
    w_rdata = r_data | ({24'd0, bus.ram_din_i} << {r_k - 3'd1, 3'b000});
    w_state_n = (w_mem_go || w_if_go) ? S_XFER :
                w_flush ? S_IDLE :
                (r_state == S_XFER && w_last) ? S_DONE :
                r_state == S_DONE ? S_IDLE : r_state;
  end
  always_ff @(posedge clk)
    if (rst == RstEnable) r_state <= S_IDLE;
    else r_state <= w_state_n;
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_owner <= OWN_NONE;
      r_we <= 1'b0;
      r_n <= 3'd0;
      r_k <= 3'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_data <= 32'd0;
      r_if_done <= 1'b0;
      r_mem_done <= 1'b0;
      r_if_data <= 32'd0;
      r_mem_data <= 32'd0;
      r_ram_addr <= '0;
      r_ram_wr <= 1'b0;
      r_ram_dout <= 8'd0;
    end else begin
      r_if_done <= 1'b0;
      r_mem_done <= 1'b0;
      r_ram_wr <= 1'b0;
      if (w_mem_go || w_if_go) begin
        r_owner <= w_mem_go ? OWN_MEM : OWN_IF;
        r_we <= w_mem_go && bus.mem_we_i;
        r_n <= w_mem_go ? len_bytes(bus.mem_len_i) : 3'd4;
        r_addr <= w_mem_go ? bus.mem_addr_i : bus.if_addr_i;
        r_wdata <= bus.mem_wdata_i;
        r_k <= 3'd0;
        r_data <= 32'd0;
      end else if (r_state == S_XFER && !w_flush) begin
        r_k <= r_k + 3'd1;
        if (!r_we && r_k != 3'd0) r_data <= w_rdata;
        if (!w_last) begin
          r_ram_addr <= w_byte_addr[ADDR_W-1:0];
          r_ram_wr <= r_we;
          r_ram_dout <= r_wdata[{r_k[1:0], 3'b000} +: 8];
        end else if (r_owner == OWN_IF) begin
          r_if_done <= 1'b1;
          r_if_data <= w_rdata;
        end else begin
          r_mem_done <= 1'b1;
          if (!r_we) r_mem_data <= w_rdata;
        end
      end
    end
  end
  assign bus.if_done_o = r_if_done;
  assign bus.if_data_o = r_if_data;
  assign bus.mem_done_o = r_mem_done;
  assign bus.mem_data_o = r_mem_data;
  assign bus.ram_addr_o = r_ram_addr;
  assign bus.ram_wr_o = r_ram_wr;
  assign bus.ram_dout_o = r_ram_dout;
  assign bus.owner_o = r_state == S_IDLE ? OWN_NONE : r_owner;
  assign bus.busy_o = r_state != S_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a done/write scoreboard checked by a separate monitor
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  mem_arbiter_if bus();
  mem_arbiter #(.ADDR_W(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic is_if; logic chk_data; logic [31:0] data; int cyc;} exp_t;
  typedef struct {logic [31:0] addr; logic [7:0] data;} wr_t;
  exp_t exp_q[$];
  wr_t wr_q[$];
  exp_t m_e;
  wr_t m_w;
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0FFF_FFFF: return 8'h34;
      32'h1000_0000: return 8'h12;
      32'h0000_0200: return 8'h7E;
      32'h0000_0040: return 8'h11;
      32'h0000_0041: return 8'h22;
      32'h0000_0042: return 8'h33;
      32'h0000_0043: return 8'h44;
      32'h0000_0080: return 8'hEF;
      32'h0000_0081: return 8'hCD;
      32'h0000_0082: return 8'hAB;
      32'h0000_0083: return 8'h89;
      32'h0000_0300: return 8'h01;
      32'h0000_0301: return 8'h02;
      32'h0000_0302: return 8'h03;
      32'h0000_0303: return 8'h04;
      32'hFFFF_FFFE: return 8'hAA;
      32'hFFFF_FFFF: return 8'hBB;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.ram_din_i = ram_byte(bus.ram_addr_o);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic exp_done(input logic is_if, input logic cd, input logic [31:0] d, input int lat);
    exp_q.push_back('{is_if, cd, d, cyc + 1 + lat});
  endtask
  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d);
    wr_q.push_back('{a, d});
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic wait_idle();
    int t = 0;
    while (bus.busy_o && t < 30) begin
      step();
      t++;
    end
    if (bus.busy_o) chk("idle_timeout", 1, 0);
  endtask
  task automatic mem_go(input logic we, input logic [1:0] len, input logic [31:0] a, input logic [31:0] wd);
    bus.mem_req_i = 1'b1;
    bus.mem_we_i = we;
    bus.mem_len_i = len;
    bus.mem_addr_i = a;
    bus.mem_wdata_i = wd;
  endtask
  always @(negedge clk) begin
    if (bus.if_done_o || bus.mem_done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", {bus.if_done_o, bus.mem_done_o}, 0);
      else begin
        m_e = exp_q.pop_front();
        chk("done_chan", {bus.if_done_o, bus.mem_done_o}, m_e.is_if ? 2'b10 : 2'b01);
        if (m_e.chk_data) chk("done_data", m_e.is_if ? bus.if_data_o : bus.mem_data_o, m_e.data);
        chk("done_cycle", cyc, m_e.cyc);
      end
    end
    if (bus.ram_wr_o) begin
      if (wr_q.size() == 0) chk("unexpected_wr", {bus.ram_addr_o, bus.ram_dout_o}, 0);
      else begin
        m_w = wr_q.pop_front();
        chk("wr_addr", bus.ram_addr_o, m_w.addr);
        chk("wr_data", bus.ram_dout_o, m_w.data);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    int t;
    bus.if_req_i = 1'b0;
    bus.if_addr_i = 32'd0;
    bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i = 1'b0;
    bus.mem_len_i = 2'b00;
    bus.mem_addr_i = 32'd0;
    bus.mem_wdata_i = 32'd0;
    repeat (2) step();
    chk("rst_ctrl", {bus.if_done_o, bus.mem_done_o, bus.ram_wr_o, bus.busy_o, bus.owner_o}, 0);
    chk("rst_data", {bus.if_data_o, bus.mem_data_o}, 0);
    chk("rst_ram", {bus.ram_addr_o, bus.ram_dout_o}, 0);
    rst = 1'b0;
    step();
    // IF word read at 0
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h0;
    exp_done(1'b1, 1'b1, 32'h0000_0013, 5);
    step();
    bus.if_req_i = 1'b0;
    chk("if_owner_xfer", bus.owner_o, OWN_IF);
    chk("if_busy_xfer", bus.busy_o, 1);
    wait_idle();
    chk("if_owner_idle", bus.owner_o, OWN_NONE);
    // MEM word store
    mem_go(1'b1, LEN_W, 32'h1000, 32'hDEAD_BEEF);
    exp_wr(32'h1000, 8'hEF);
    exp_wr(32'h1001, 8'hBE);
    exp_wr(32'h1002, 8'hAD);
    exp_wr(32'h1003, 8'hDE);
    exp_done(1'b0, 1'b0, 32'h0, 5);
    step();
    bus.mem_req_i = 1'b0;
    chk("st_owner", bus.owner_o, OWN_MEM);
    wait_idle();
    // MEM half load across 0x0FFFFFFF
    mem_go(1'b0, LEN_H, 32'h0FFF_FFFF, 32'h0);
    exp_done(1'b0, 1'b1, 32'h0000_1234, 3);
    step();
    bus.mem_req_i = 1'b0;
    wait_idle();
    // MEM half store
    mem_go(1'b1, LEN_H, 32'h2000, 32'h1111_CAFE);
    exp_wr(32'h2000, 8'hFE);
    exp_wr(32'h2001, 8'hCA);
    exp_done(1'b0, 1'b0, 32'h0, 3);
    step();
    bus.mem_req_i = 1'b0;
    wait_idle();
    // length 10 behaves as a word
    mem_go(1'b0, 2'b10, 32'h300, 32'h0);
    exp_done(1'b0, 1'b1, 32'h0403_0201, 5);
    step();
    bus.mem_req_i = 1'b0;
    wait_idle();
    // IF fetch wrapping past 0xFFFFFFFF
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'hFFFF_FFFE;
    exp_done(1'b1, 1'b1, 32'h0013_BBAA, 5);
    step();
    bus.if_req_i = 1'b0;
    wait_idle();
    // simultaneous requests: MEM byte first, IF after the DONE cycle
    c = cyc;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h40;
    mem_go(1'b0, LEN_B, 32'h200, 32'h0);
    exp_done(1'b0, 1'b1, 32'h0000_007E, 2);
    exp_done(1'b1, 1'b1, 32'h4433_2211, 9);
    step();
    bus.mem_req_i = 1'b0;
    chk("sim_mem_wins", bus.owner_o, OWN_MEM);
    t = 0;
    while (bus.owner_o != OWN_IF && t < 12) begin
      step();
      t++;
    end
    chk("sim_if_start", cyc, c + 5);
    bus.if_req_i = 1'b0;
    wait_idle();
    // flush while byte 2 of an IF fetch is on the bus
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h60;
    step();
    bus.if_req_i = 1'b0;
    repeat (3) step();
    chk("fl_byte2_addr", bus.ram_addr_o, 32'h62);
    bus.if_flush_i = 1'b1;
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h80;
    exp_done(1'b1, 1'b1, 32'h89AB_CDEF, 6);
    step();
    chk("fl_idle_busy", bus.busy_o, 0);
    chk("fl_idle_owner", bus.owner_o, OWN_NONE);
    bus.if_flush_i = 1'b0;
    step();
    chk("fl_target_owner", bus.owner_o, OWN_IF);
    bus.if_req_i = 1'b0;
    wait_idle();
    // reset in the middle of a word store
    mem_go(1'b1, LEN_W, 32'h3000, 32'h1234_5678);
    exp_wr(32'h3000, 8'h78);
    exp_wr(32'h3001, 8'h56);
    step();
    bus.mem_req_i = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_mid_ctrl", {bus.ram_wr_o, bus.busy_o, bus.owner_o, bus.mem_done_o}, 0);
    rst = 1'b0;
    repeat (6) step();
    chk("rst_mid_idle", bus.busy_o, 0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
